fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage driving the IF/ID pipeline register from the front. Holds the program counter and issues one word-aligned request at a time to a variable-latency instruction memory. It delivers each returned word with its PC onto the IF/ID inputs and generates that register's `load` and `if_flush` controls. It applies stalls from the hazard unit and redirects from branch/jump resolution, and discards in-flight responses made stale by a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `stall`  in  1: hazard unit holds IF/ID. No delivery occurs and IF/ID keeps its contents.
- `redirect`  in  1: taken branch/jump. Fetch restarts at `redirect_pc`.
- `redirect_pc`  in  32: redirect target. Bits [1:0] are ignored.
- `imem_req`  out  1: request valid.
- `imem_addr`  out  32: request address. Bits [1:0] are always 0.
- `imem_ready`  in  1: memory accepts the request this cycle.
- `imem_rvalid`  in  1: response valid. At most one per accepted request, earliest the cycle after acceptance.
- `imem_rdata`  in  32: response word.
- `pc_out`  out  32: PC of the delivered word. Goes to IF/ID `pc_in`.
- `instruction_out`  out  32: delivered word. Goes to IF/ID `instruction_memory_in`.
- `if_id_load`  out  1: IF/ID `load`.
- `if_flush`  out  1: IF/ID `if_flush`.

## Operation
- Registers:
  - `pc_reg`: next request address.
  - `req_pc`: address of the in-flight or held word.
  - `hold_data`.
  - `drop` flag.
  - `state`.
- States: IDLE, REQ, WAIT, HOLD.
- Reset (asserted, async): state=IDLE, `pc_reg`=`req_pc`=RESET_PC, `hold_data`=0, `drop`=0. Outputs while asserted: `imem_req`=0, `if_id_load`=0, `if_flush`=0, `instruction_out`=0, `pc_out`=RESET_PC, `imem_addr`=RESET_PC.
- IDLE → REQ unconditionally one cycle after reset release.
- REQ:
  - Drives `imem_req`=1 and `imem_addr`={`pc_reg`[31:2],2'b00}.
  - On `imem_ready`: `req_pc`←`pc_reg`, `pc_reg`←`pc_reg`+4 (mod 2^32, wraps FFFF_FFFC→0000_0000), then → WAIT.
  - The address may change while not yet accepted.
- WAIT:
  - On `imem_rvalid` with `drop`=1: clear `drop`, → REQ, nothing delivered.
  - On `imem_rvalid` with `drop`=0: if `redirect`, discard the word and go → REQ. Else if `stall`, `hold_data`←`imem_rdata` and go → HOLD. Else deliver and go → REQ.
- HOLD: if `redirect`, discard and go → REQ. Else if !`stall`, deliver `hold_data` and go → REQ.
- Redirect (any state except IDLE, highest priority): `pc_reg`←{`redirect_pc`[31:2],2'b00}; this overrides the +4 update.
  - WAIT without `imem_rvalid`: `drop`←1.
  - REQ with `imem_ready` the same cycle: request counts as accepted, → WAIT with `drop`←1.
- Delivery cycle: `if_id_load`=1, `if_flush`=0, `pc_out`=`req_pc`, `instruction_out`=`imem_rdata` (from WAIT) or `hold_data` (from HOLD).
- IF/ID control, out of reset:
  - `redirect`=1: `if_id_load`=0, `if_flush`=1. Redirect wins over stall.
  - Else `stall`=1: both 0.
  - Else delivering: load=1, flush=0.
  - Else: load=0, flush=1, which inserts a zero bubble.
- Outside delivery: `pc_out`=`req_pc`, `instruction_out`=0.
- `imem_rvalid` in IDLE, REQ or HOLD is ignored.

## Timing
- Control outputs are combinational from state and inputs (`stall`, `redirect`, `imem_ready`, `imem_rvalid`). All state updates happen on the rising `clock` edge.
- Minimum per-instruction cost is 2 cycles: REQ with ready, then WAIT with rvalid. Memory latency L ≥ 1 adds L−1 bubble cycles.
- The word delivered in cycle N is in IF/ID after edge N→N+1.
- After a redirect in cycle N, the first request to `redirect_pc` is issued in cycle N+1, or after the dropped response if one is outstanding.
- Asserting reset mid-request abandons the request immediately. A pre-reset response is ignored (state IDLE/REQ).

## Test plan
- Reset release, memory always ready, latency 1: `imem_addr` sequence 0,4,8; loads deliver (0,word0), (4,word1); flush=1 on each non-delivery cycle.
- Latency 3 with `stall` held high across the response, released 2 cycles later: word captured into HOLD, delivered in the release cycle with the correct `req_pc`, and load=flush=0 during the stall.
- Redirect to 0x0000_0103 in WAIT, response 2 cycles later: response dropped with no load, next `imem_addr`=0x100, and flush=1 in the redirect cycle.
- `redirect` and `stall` together while in HOLD: flush=1, load=0, held word discarded, next request to the target.
- `pc_reg`=0xFFFF_FFFC accepted: next `imem_addr`=0x0000_0000.
- Reset asserted in WAIT, then a late `imem_rvalid` after release: outputs at reset values, late response ignored, first request to RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch stage's control inputs, the instruction-memory handshake
// and the IF/ID register feed into one interface.
//   master : the fetch unit (drives imem request and IF/ID inputs)
//   slave  : the environment (hazard unit, branch resolution, memory, IF/ID)
// Signals:
//   stall, redirect, redirect_pc      hazard / branch-resolution controls
//   imem_req, imem_addr, imem_ready   request channel
//   imem_rvalid, imem_rdata           response channel
//   pc_out, instruction_out           IF/ID data inputs
//   if_id_load, if_flush              IF/ID controls
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        if_id_load;
  logic        if_flush;

  modport master (
    input  stall, redirect, redirect_pc,
    input  imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr,
    output pc_out, instruction_out, if_id_load, if_flush
  );

  modport slave (
    output stall, redirect, redirect_pc,
    output imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr,
    input  pc_out, instruction_out, if_id_load, if_flush
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Keeps the program counter, issues one word-aligned
// request at a time to a variable-latency instruction memory, and hands each
// returned word plus its PC to the IF/ID register together with that
// register's load / flush controls. Stalls hold IF/ID; redirects restart
// fetch at a new target and cause an outstanding response to be discarded.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : fetch_unit_if.master (controls, imem handshake, IF/ID feed)
// Parameters:
//   RESET_PC : first fetch address after reset
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic [31:0] req_pc_q,    req_pc_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic        drop_q,      drop_d;

  logic        deliver;
  logic        deliver_from_hold;
  logic [31:0] redirect_target;
  logic        unused_redirect_low;

  // The low two target bits are not meaningful for word fetch.
  assign redirect_target     = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_low = ^bus.redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    req_pc_d          = req_pc_q;
    hold_data_d       = hold_data_q;
    drop_d            = drop_q;
    deliver           = 1'b0;
    deliver_from_hold = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        if (bus.imem_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = WAIT;
          // A redirect in the acceptance cycle still leaves a response on
          // its way back; it must be swallowed when it arrives.
          drop_d   = bus.redirect;
        end
      end

      WAIT: begin
        if (bus.imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else if (bus.redirect) begin
            state_d = REQ;
          end else if (bus.stall) begin
            hold_data_d = bus.imem_rdata;
            state_d     = HOLD;
          end else begin
            deliver = 1'b1;
            state_d = REQ;
          end
        end else if (bus.redirect) begin
          drop_d = 1'b1;
        end
      end

      HOLD: begin
        if (bus.redirect) begin
          state_d = REQ;
        end else if (!bus.stall) begin
          deliver           = 1'b1;
          deliver_from_hold = 1'b1;
          state_d           = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Redirect target takes precedence over the sequential +4 update.
    if (bus.redirect && (state_q != IDLE)) begin
      pc_d = redirect_target;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      hold_data_q <= 32'd0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      hold_data_q <= hold_data_d;
      drop_q      <= drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The state registers already hold their reset values while reset is low,
  // so only the input-dependent outputs need explicit gating.
  assign bus.imem_req  = (state_q == REQ);
  assign bus.imem_addr = {pc_q[31:2], 2'b00};
  assign bus.pc_out    = req_pc_q;

  assign bus.if_id_load = reset & deliver;
  // Flush whenever IF/ID is not being loaded and not being held, so a bubble
  // enters the pipe; redirect always flushes, even over a stall.
  assign bus.if_flush   = reset & (bus.redirect | (!bus.stall & !deliver));

  always_comb begin
    bus.instruction_out = 32'd0;
    if (reset && deliver) begin
      bus.instruction_out = deliver_from_hold ? hold_data_q : bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst_n;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: what the fetch unit is doing, at transaction level.
  bit          m_started;   // one cycle has passed since reset release
  bit          m_out;       // a request has been accepted, answer not yet seen
  bit          m_stale;     // that answer must be thrown away
  bit          m_hold;      // a word is parked waiting for the stall to clear
  logic [31:0] m_held;
  logic [31:0] m_next;      // address of the next request
  logic [31:0] m_cur;       // address of the word in flight / parked

  // Memory model
  bit          mem_pending;
  int          mem_cnt;
  logic [31:0] mem_addr;

  // Observed values from the most recent step
  logic        o_req, o_load, o_flush, o_acc;
  logic [31:0] o_addr, o_pc, o_instr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_out = 0; m_stale = 0; m_hold = 0; m_held = '0;
    m_next = RESET_PC; m_cur = RESET_PC;
  endtask

  // One clock cycle: drive inputs, check outputs, advance models at the edge.
  task automatic step(input bit rst_v, input bit st, input bit rd,
                      input logic [31:0] rpc, input bit rdy, input int lat,
                      input bit spur);
    logic e_req, e_load, e_flush, dlv, rv, rdy_eff;
    logic [31:0] e_addr, e_pc, e_instr, rdat;
    #1;
    rst_n   = rst_v;
    rv      = mem_pending && (mem_cnt == 0);
    rdat    = rv ? word_of(mem_addr) : $urandom;
    if (!rv && spur && !mem_pending && !m_out) rv = 1;
    rdy_eff = rdy && !mem_pending;
    bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc;
    bus.imem_ready = rdy_eff; bus.imem_rvalid = rv; bus.imem_rdata = rdat;
    #3;
    if (!rst_v) begin
      e_req = 0; e_addr = RESET_PC; e_pc = RESET_PC;
      e_load = 0; e_flush = 0; e_instr = 0; dlv = 0;
    end else begin
      e_req   = m_started && !m_out && !m_hold;
      e_addr  = m_next;
      e_pc    = m_cur;
      dlv     = !rd && !st && ((m_out && rv && !m_stale) || m_hold);
      e_load  = dlv;
      e_flush = rd || (!st && !dlv);
      e_instr = dlv ? (m_hold ? m_held : rdat) : 32'd0;
    end
    o_req = bus.imem_req; o_addr = bus.imem_addr; o_load = bus.if_id_load;
    o_flush = bus.if_flush; o_pc = bus.pc_out; o_instr = bus.instruction_out;
    o_acc = o_req && rdy_eff;
    chk("imem_req", {31'd0, o_req}, {31'd0, e_req});
    if (e_req) chk("imem_addr", o_addr, e_addr);
    chk("if_id_load", {31'd0, o_load}, {31'd0, e_load});
    chk("if_flush", {31'd0, o_flush}, {31'd0, e_flush});
    chk("pc_out", o_pc, e_pc);
    chk("instruction_out", o_instr, e_instr);
    if (o_load) $display("deliver t=%0t pc=%h instr=%h", $time, o_pc, o_instr);
    @(posedge clk);
    // memory
    if (mem_pending) begin
      if (mem_cnt == 0) mem_pending = 0;
      else mem_cnt--;
    end
    if (rst_v && e_req && rdy_eff) begin
      mem_pending = 1; mem_cnt = lat - 1; mem_addr = m_next;
    end
    // fetch model
    if (!rst_v) model_reset();
    else if (!m_started) m_started = 1;
    else begin
      if (e_req && rdy_eff) begin
        m_cur = m_next; m_next = m_next + 32'd4; m_out = 1; m_stale = rd;
      end else if (m_out && rv) begin
        m_out = 0;
        if (!m_stale && !rd && st) begin m_hold = 1; m_held = rdat; end
        m_stale = 0;
      end else if (m_out && rd) begin
        m_stale = 1;
      end else if (m_hold && (rd || !st)) begin
        m_hold = 0;
      end
      if (rd) m_next = {rpc[31:2], 2'b00};
    end
  endtask

  initial begin
    logic [31:0] acc_q[$];
    logic [31:0] rp;
    int n;
    model_reset();
    mem_pending = 0; mem_cnt = 0; mem_addr = '0;
    rst_n = 0;
    bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
    bus.imem_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = '0;

    // Reset held for two cycles
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 1);

    // Always ready, latency 1: addresses 0,4,8 and deliveries of words 0,4
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 1, 1, 0);
      if (o_acc) acc_q.push_back(o_addr);
      if (i == 2) begin chk("tp1_pc0", o_pc, 32'h0); chk("tp1_w0", o_instr, word_of(32'h0)); end
      if (i == 4) begin chk("tp1_pc4", o_pc, 32'h4); chk("tp1_w4", o_instr, word_of(32'h4)); end
      if (i == 3) chk("tp1_flush", {31'd0, o_flush}, 32'd1);
    end
    step(1, 0, 0, 0, 1, 3, 0);          // request 8 accepted, latency 3
    if (o_acc) acc_q.push_back(o_addr);
    chk("tp1_naddr", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("tp1_a0", acc_q[0], 32'h0); chk("tp1_a1", acc_q[1], 32'h4); chk("tp1_a2", acc_q[2], 32'h8);
    end

    // Latency 3, stall across the response, released two cycles later
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);          // response arrives under stall
    chk("tp2_load_stall", {31'd0, o_load}, 32'd0);
    chk("tp2_flush_stall", {31'd0, o_flush}, 32'd0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);          // release: held word goes out
    chk("tp2_load", {31'd0, o_load}, 32'd1);
    chk("tp2_pc", o_pc, 32'h8);
    chk("tp2_word", o_instr, word_of(32'h8));

    // Redirect to 0x103 while waiting; response two cycles later is dropped
    step(1, 0, 0, 0, 1, 3, 0);          // accept 0xC
    step(1, 0, 1, 32'h0000_0103, 0, 1, 0);
    chk("tp3_flush", {31'd0, o_flush}, 32'd1);
    chk("tp3_load", {31'd0, o_load}, 32'd0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);          // stale response
    chk("tp3_drop", {31'd0, o_load}, 32'd0);
    step(1, 0, 0, 0, 1, 1, 0);
    chk("tp3_addr", o_addr, 32'h0000_0100);

    // Redirect together with stall while holding
    step(1, 1, 0, 0, 0, 1, 0);          // response parked
    step(1, 1, 1, 32'h0000_0200, 0, 1, 0);
    chk("tp4_flush", {31'd0, o_flush}, 32'd1);
    chk("tp4_load", {31'd0, o_load}, 32'd0);
    step(1, 0, 0, 0, 1, 1, 0);
    chk("tp4_addr", o_addr, 32'h0000_0200);

    // Wrap from 0xFFFF_FFFC to 0
    step(1, 0, 1, 32'hFFFF_FFFE, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1, 0);
    chk("tp5_top", o_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("tp5_word", o_instr, word_of(32'hFFFF_FFFC));
    step(1, 0, 0, 0, 1, 5, 0);
    chk("tp5_wrap", o_addr, 32'h0000_0000);

    // Reset in WAIT, late response after release is ignored
    step(1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("tp6_rst_req", {31'd0, o_req}, 32'd0);
    chk("tp6_rst_flush", {31'd0, o_flush}, 32'd0);
    n = 0;
    o_acc = 0;
    while (!o_acc && n < 10) begin
      step(1, 0, 0, 0, 1, 1, 0);
      chk("tp6_noload", {31'd0, o_load}, 32'd0);
      n++;
    end
    chk("tp6_accepted", {31'd0, o_acc}, 32'd1);
    chk("tp6_addr", o_addr, RESET_PC);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rp = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : $urandom;
      step(1, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, rp,
           $urandom_range(0, 9) < 6, $urandom_range(1, 4), $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
